// File: rtl/hqc_uart_pkg.sv
// HQC UART link: shared constants, frame layout and FSM encoding.
// Used by both the CT/SK loader and the shared-secret return path.
package hqc_uart_pkg;

  localparam int HQC_SS_WORDS = 8;
  localparam int HQC_SS_BYTES = HQC_SS_WORDS * 8;

  localparam int   FRAME_BITS = 10;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_SEND,
    ST_DRAIN,
    ST_FIN
  } ss_state_t;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer: baud counter plus 10-bit frame shifter.
// ready also rises in the last stop-bit cycle so frames can abut.
module uart_tx_byte
  import hqc_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] shreg;
  logic [3:0]            bit_idx;
  logic [CNT_W-1:0]      baud_cnt;
  logic                  active;
  logic                  tick;
  logic                  frame_end;

  assign tick      = baud_cnt == CNT_MAX;
  assign frame_end = active && tick && (bit_idx == LAST_BIT);
  assign ready     = !active || frame_end;
  assign tx        = shreg[0];

  // Idle shifter holds all ones, so tx idles high straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '1;
      bit_idx  <= '0;
      baud_cnt <= '0;
      active   <= 1'b0;
    end else if (valid && ready) begin
      shreg    <= {STOP_BIT, data, START_BIT};
      bit_idx  <= '0;
      baud_cnt <= '0;
      active   <= 1'b1;
    end else if (active) begin
      if (tick) begin
        baud_cnt <= '0;
        shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
        bit_idx  <= bit_idx + 4'd1;
        if (bit_idx == LAST_BIT) begin
          active <= 1'b0;
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/hqc_ss_uart_tx.sv
// HQC decap return path: streams ss_mem over UART 8N1, byte0 = word[7:0].
// Next word is fetched while byte 7 of the current word is on the line.
module hqc_ss_uart_tx
  import hqc_uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115_200,
  parameter int SS_WORDS = HQC_SS_WORDS,
  parameter int ADDR_W   =
    (SS_WORDS > 1) ? $clog2(SS_WORDS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [63:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
  localparam logic [ADDR_W-1:0] LAST_WORD =
    ADDR_W'(SS_WORDS - 1);

  ss_state_t         state;
  ss_state_t         state_nx;
  logic [63:0]       word_q;
  logic [2:0]        byte_idx;
  logic [ADDR_W-1:0] word_cnt;
  logic              byte_valid;
  logic              byte_ready;
  logic              byte_take;
  logic [7:0]        byte_data;
  logic              last_byte;
  logic              last_word;
  logic              launch;

  assign byte_take = byte_valid && byte_ready;
  assign last_byte = byte_idx == 3'd7;
  assign last_word = word_cnt == LAST_WORD;
  assign launch    = start &&
    (state == ST_IDLE || state == ST_FIN);
  assign byte_data = word_q[{byte_idx, 3'b000} +: 8];
  assign mem_addr  = word_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_FETCH;
      end
      ST_FETCH: state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_SEND;
      ST_SEND: begin
        if (byte_take && last_byte) begin
          state_nx = last_word ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (byte_ready) state_nx = ST_FIN;
      end
      ST_FIN: state_nx = start ? ST_FETCH : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    byte_valid = 1'b0;
    unique case (state)
      ST_IDLE: ;
      ST_FETCH: begin
        mem_en = 1'b1;
        busy   = 1'b1;
      end
      ST_LATCH: busy = 1'b1;
      ST_SEND: begin
        busy       = 1'b1;
        byte_valid = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      ST_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  // word_cnt doubles as mem_addr, so it only moves on a fetch or a launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q   <= '0;
      byte_idx <= '0;
      word_cnt <= '0;
    end else begin
      if (launch) begin
        word_cnt <= '0;
      end else if (byte_take && last_byte && !last_word) begin
        word_cnt <= word_cnt + ADDR_W'(1);
      end
      if (state == ST_LATCH) begin
        word_q   <= mem_rdata;
        byte_idx <= '0;
      end else if (byte_take) begin
        byte_idx <= byte_idx + 3'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CPB)
  ) u_tx_byte (
    .clk  (clk),
    .rst  (rst),
    .valid(byte_valid),
    .data (byte_data),
    .ready(byte_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_hqc_ss_uart_tx.sv
// Bench for hqc_ss_uart_tx: UART RX model plus stream-level reference,
// checked every cycle on an 8-word and a 1-word instance.
module tb_hqc_ss_uart_tx;

  localparam int CF   = 1_000_000;
  localparam int BR   = 100_000;
  localparam int CPB  = 10;
  localparam int FLEN = 10 * CPB;
  localparam int NW0  = 8;
  localparam int NW1  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  start = 2'b00;
  logic        men0, men1;
  logic [2:0]  addr0;
  logic [0:0]  addr1;
  logic [63:0] rd0, rd1;
  logic        tx0, tx1, busy0, busy1, done0, done1;
  logic [63:0] mem8 [8];
  logic [63:0] mem1;

  int n_vec = 0;
  int n_err = 0;

  int   len_m [2];
  int   pos_m [2];
  int   k_m   [2];
  int   wait_m[2];
  int   lim_m [2];
  int   fetch_m[2];
  int   held_m[2];
  bit   in_dump[2];
  bit   done_due[2];
  bit   men_prev[2];
  logic [7:0] exp_b [2][64];
  logic [9:0] frame_m[2];
  logic [7:0] rxsh[2];
  logic [7:0] rx_log[2][1024];
  int   rx_cnt[2]   = '{0, 0};
  int   done_cnt[2] = '{0, 0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (men0) rd0 <= mem8[addr0];
    if (men1) rd1 <= mem1;
  end

  hqc_ss_uart_tx #(
    .CLK_FREQ(CF), .BAUD(BR), .SS_WORDS(NW0)
  ) u_dut8 (
    .clk(clk), .rst(rst), .start(start[0]),
    .mem_en(men0), .mem_addr(addr0), .mem_rdata(rd0),
    .tx(tx0), .busy(busy0), .done(done0)
  );

  hqc_ss_uart_tx #(
    .CLK_FREQ(CF), .BAUD(BR), .SS_WORDS(NW1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .mem_en(men1), .mem_addr(addr1), .mem_rdata(rd1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input int c,
                     input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s ch%0d @%0t: got %0h, expected %0h",
               nm, c, $time, got, exp);
    end
  endtask

  // One cycle of the reference: stream of expected bytes, RX sampler,
  // handshake and fetch rules, all derived from the dump contents.
  task automatic mon(input int c, input logic t, input logic b,
                     input logic d, input logic me, input int ad,
                     input logic st);
    bit dexp, bexp;
    int nw;
    nw = (c == 0) ? NW0 : NW1;
    if (rst) begin
      chk("rst_tx", c, t, 1);
      chk("rst_busy", c, b, 0);
      chk("rst_done", c, d, 0);
      chk("rst_mem_en", c, me, 0);
      len_m[c] = 0; pos_m[c] = 0; k_m[c] = -1;
      in_dump[c] = 0; done_due[c] = 0; men_prev[c] = 0;
      held_m[c] = 0; fetch_m[c] = 0;
      return;
    end
    dexp = done_due[c];
    done_due[c] = 0;
    chk("done", c, d, dexp);
    bexp = in_dump[c] && !dexp;
    chk("busy", c, b, bexp);
    if (dexp) begin
      chk("fetch_count", c, fetch_m[c], nw);
      in_dump[c] = 0;
      done_cnt[c]++;
    end
    if (me) begin
      chk("mem_en_ok", c, in_dump[c] && !men_prev[c], 1);
      chk("mem_addr", c, ad, fetch_m[c]);
      held_m[c] = fetch_m[c];
      fetch_m[c]++;
    end else begin
      chk("mem_addr_hold", c, ad, held_m[c]);
    end
    men_prev[c] = me;
    if (k_m[c] < 0) begin
      if (pos_m[c] < len_m[c]) begin
        if (!t) begin
          chk("frame_gap", c, wait_m[c] <= lim_m[c], 1);
          frame_m[c] = {1'b1, exp_b[c][pos_m[c]], 1'b0};
          pos_m[c]++;
          k_m[c] = 0;
        end else begin
          wait_m[c]++;
        end
      end else begin
        chk("tx_idle", c, t, 1);
      end
    end
    if (k_m[c] >= 0) begin
      chk("tx_bit", c, t, frame_m[c][k_m[c] / CPB]);
      if (k_m[c] % CPB == CPB / 2 &&
          k_m[c] / CPB >= 1 && k_m[c] / CPB <= 8) begin
        rxsh[c] = {t, rxsh[c][7:1]};
      end
      if (k_m[c] == FLEN - CPB / 2) begin
        chk("rx_stop", c, t, 1);
        rx_log[c][rx_cnt[c] % 1024] = rxsh[c];
        rx_cnt[c]++;
        chk("rx_byte", c, rxsh[c], exp_b[c][pos_m[c] - 1]);
      end
      k_m[c]++;
      if (k_m[c] == FLEN) begin
        k_m[c] = -1;
        wait_m[c] = 0;
        lim_m[c] = 2;
        if (pos_m[c] == len_m[c]) done_due[c] = 1;
      end
    end
    if (st && !bexp) begin
      in_dump[c] = 1;
      fetch_m[c] = 0;
      pos_m[c] = 0;
      wait_m[c] = 0;
      lim_m[c] = 3;
      len_m[c] = 8 * nw;
      for (int w = 0; w < nw; w++) begin
        for (int i = 0; i < 8; i++) begin
          exp_b[c][8*w+i] = (c == 0) ? mem8[w][8*i +: 8]
                                     : mem1[8*i +: 8];
        end
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    mon(0, tx0, busy0, done0, men0, int'(addr0), start[0]);
    mon(1, tx1, busy1, done1, men1, int'(addr1), start[1]);
  end

  task automatic pulse(input int c);
    @(posedge clk);
    #1 start[c] = 1'b1;
    @(posedge clk);
    #1 start[c] = 1'b0;
  endtask

  task automatic wait_done(input int c, input int budget);
    int base;
    base = done_cnt[c];
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt[c] != base) break;
    end
    chk("done_timeout", c, done_cnt[c] != base, 1);
  endtask

  task automatic wait_pos(input int c, input int p, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (pos_m[c] >= p) break;
    end
    chk("pos_timeout", c, pos_m[c] >= p, 1);
  endtask

  task automatic rand_mem();
    for (int w = 0; w < 8; w++) begin
      mem8[w] = {$urandom, $urandom};
    end
  endtask

  task automatic chk_dump(input string nm, input int b0);
    for (int i = 0; i < 64; i++) begin
      chk(nm, 0, rx_log[0][(b0 + i) % 1024],
          mem8[i / 8][8 * (i % 8) +: 8]);
    end
  endtask

  initial begin
    int b0, d0;
    mem1 = 64'h0807060504030201;
    for (int w = 0; w < 8; w++) mem8[w] = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", 0, tx0, 1);
    chk("reset_busy", 0, busy0, 0);
    chk("reset_done", 0, done0, 0);
    chk("reset_mem_en", 0, men0, 0);
    chk("reset_addr", 0, addr0, 0);
    rst = 1'b0;

    // idle line, no fetches
    repeat (1000) @(posedge clk);
    #1;
    chk("idle_tx", 0, tx0, 1);
    chk("idle_fetch", 0, fetch_m[0], 0);

    // single word, fixed bytes
    b0 = rx_cnt[1];
    pulse(1);
    wait_done(1, 8 * FLEN + 50);
    chk("t1_count", 1, rx_cnt[1] - b0, 8);
    for (int i = 0; i < 8; i++) begin
      chk("t1_byte", 1, rx_log[1][(b0 + i) % 1024], i + 1);
    end

    // eight words of {8{w}}
    for (int w = 0; w < 8; w++) mem8[w] = {8{8'(w)}};
    b0 = rx_cnt[0];
    pulse(0);
    wait_done(0, 64 * FLEN + 200);
    chk("t2_count", 0, rx_cnt[0] - b0, 64);
    for (int i = 0; i < 64; i++) begin
      chk("t2_byte", 0, rx_log[0][(b0 + i) % 1024], i / 8);
    end

    // start re-pulsed during byte 3
    rand_mem();
    b0 = rx_cnt[0];
    d0 = done_cnt[0];
    pulse(0);
    wait_pos(0, 4, 8 * FLEN);
    repeat ($urandom_range(0, 80)) @(posedge clk);
    pulse(0);
    wait_done(0, 64 * FLEN + 200);
    repeat (300) @(posedge clk);
    chk("t3_dones", 0, done_cnt[0] - d0, 1);
    chk("t3_count", 0, rx_cnt[0] - b0, 64);
    chk_dump("t3_byte", b0);

    // reset in a data bit of byte 5, then a clean dump
    rand_mem();
    pulse(0);
    wait_pos(0, 6, 10 * FLEN);
    repeat (14 + 10 * $urandom_range(0, 7)) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t4_tx", 0, tx0, 1);
    chk("t4_busy", 0, busy0, 0);
    chk("t4_done", 0, done0, 0);
    d0 = done_cnt[0];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (50) @(posedge clk);
    chk("t4_no_done", 0, done_cnt[0] - d0, 0);
    rand_mem();
    b0 = rx_cnt[0];
    pulse(0);
    wait_done(0, 64 * FLEN + 200);
    chk("t4_count", 0, rx_cnt[0] - b0, 64);
    chk_dump("t4_byte", b0);

    // start held through the done cycle
    rand_mem();
    b0 = rx_cnt[0];
    d0 = done_cnt[0];
    pulse(0);
    wait_pos(0, 64, 64 * FLEN + 200);
    #1 start[0] = 1'b1;
    wait_done(0, 2 * FLEN);
    #1 start[0] = 1'b0;
    wait_done(0, 64 * FLEN + 200);
    chk("t5_dones", 0, done_cnt[0] - d0, 2);
    chk("t5_count", 0, rx_cnt[0] - b0, 128);
    chk_dump("t5_first", b0);
    chk_dump("t5_second", b0 + 64);

    repeat (20) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
